// File: rtl/move_scheduler.sv
// Paced movement command scheduler: manual d-pad FIFO or autonomous requests, one command per tick.
// Optional feature macro MOVE_AUTOREPEAT_EN: a direction held alone re-pushes every REPEAT_TICKS ticks.
module move_scheduler #(
  parameter int TICK_DIV     = 12_500_000,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_TICKS = 2
) (
  input  logic                          clock_50,
  input  logic                          reset_key,
  input  logic                          mode,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic                          btn_left,
  input  logic                          btn_right,
  input  logic                          btn_start,
  input  logic                          auto_req_valid,
  input  logic [1:0]                    auto_req_dir,
  output logic                          auto_req_ready,
  output logic                          cmd_valid,
  output logic [1:0]                    cmd_dir,
  input  logic                          cmd_ready,
  output logic                          paused,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [15:0]                   move_count
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t        state_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_pending_q;
  logic [3:0]    btn_q;
  logic          start_q, mode_q, paused_q, overflow_q, cmd_valid_q;
  logic [1:0]    cmd_dir_q;
  logic [15:0]   move_count_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    mem_q [FIFO_DEPTH];

  logic [3:0] btn_lvl, btn_rise, push_sel;
  logic       tick_wrap, tick_now, idle_go, mode_chg, pop, load_auto;
  logic       push_req, push_ok, push_drop;
  logic [1:0] push_dir;

  assign btn_lvl    = {btn_right, btn_left, btn_down, btn_up};
  assign btn_rise   = btn_lvl & ~btn_q;
  assign tick_wrap  = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TW'(1);
  // A wrap seen while IDLE loads in the same cycle, so cmd_valid rises one cycle after the wrap.
  assign tick_now   = tick_pending_q | tick_wrap;
  assign idle_go    = (state_q == S_IDLE) & tick_now & ~paused_q;
  assign mode_chg   = mode ^ mode_q;
  assign pop        = idle_go & ~mode & (count_q != '0);
  assign load_auto  = idle_go & mode & auto_req_valid;
  assign auto_req_ready = reset_key & idle_go & mode;

`ifdef MOVE_AUTOREPEAT_EN
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rpt_cnt_q [4];
  logic [3:0]    held_alone, rpt_hit;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      held_alone[i] = (btn_lvl == (4'b0001 << i));
      rpt_hit[i]    = held_alone[i] & ~(|btn_rise) & tick_wrap & (rpt_cnt_q[i] == RPT_LAST);
    end
  end

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      for (int i = 0; i < 4; i++) rpt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!held_alone[i] || (|btn_rise)) rpt_cnt_q[i] <= '0;
        else if (tick_wrap) rpt_cnt_q[i] <= rpt_hit[i] ? '0 : rpt_cnt_q[i] + RW'(1);
      end
    end
  end
`else
  logic [3:0] rpt_hit;
  assign rpt_hit = 4'b0000;
`endif

  // Fresh edges outrank repeats; among candidates the lowest direction code wins.
  assign push_sel = (|btn_rise) ? btn_rise : rpt_hit;

  always_comb begin
    push_req = 1'b0;
    push_dir = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (push_sel[i]) begin
        push_req = 1'b1;
        push_dir = 2'(i);
      end
    end
  end

  assign push_ok   = push_req & ~mode & ~mode_chg & ((count_q != FULL_CNT) | pop);
  assign push_drop = push_req & ~mode & ~mode_chg & (count_q == FULL_CNT) & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mode_chg) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push_ok) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock_50) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dir;
  end

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      tick_cnt_q     <= '0;
      tick_pending_q <= 1'b0;
      btn_q          <= '0;
      start_q        <= 1'b0;
      mode_q         <= 1'b0;
      paused_q       <= 1'b0;
      overflow_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      if (pop || load_auto) tick_pending_q <= 1'b0;
      else if (tick_wrap)   tick_pending_q <= 1'b1;
      btn_q   <= btn_lvl;
      start_q <= btn_start;
      mode_q  <= mode;
      if (btn_start && !start_q) paused_q <= ~paused_q;
      if (push_drop) overflow_q <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      state_q      <= S_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_dir_q    <= 2'd0;
      move_count_q <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cmd_dir_q   <= mem_q[rd_ptr_q];
            cmd_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end else if (load_auto) begin
            cmd_dir_q   <= auto_req_dir;
            cmd_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q  <= 1'b0;
            move_count_q <= move_count_q + 16'd1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_dir    = cmd_dir_q;
  assign paused     = paused_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign move_count = move_count_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: stimulus queues expected directions, a monitor checks handshakes.
module tb_move_scheduler;
  localparam int TICK_DIV   = 4;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [3:0]  btn;
  logic        start;
  logic        auto_valid;
  logic [1:0]  auto_dir;
  logic        auto_ready;
  logic        cmd_valid;
  logic [1:0]  cmd_dir;
  logic        cmd_ready;
  logic        paused;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic [15:0] move_count;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  move_scheduler #(.TICK_DIV(TICK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .REPEAT_TICKS(2)) dut (
    .clock_50(clk), .reset_key(rst_n), .mode(mode),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
    .btn_start(start), .auto_req_valid(auto_valid), .auto_req_dir(auto_dir),
    .auto_req_ready(auto_ready), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .cmd_ready(cmd_ready), .paused(paused), .fifo_count(fifo_count),
    .overflow(overflow), .move_count(move_count)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    step(1);
    btn[idx] = 1'b0;
    step(1);
  endtask

  task automatic press_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
  endtask

  task automatic wait_valid(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (cmd_valid) break;
      step(1);
    end
    check(name, int'(cmd_valid), 1);
  endtask

  task automatic wait_moves(input string name, input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (int'(move_count) == target) break;
      step(1);
    end
    check(name, int'(move_count), target);
  endtask

  task automatic watch_quiet(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (cmd_valid) seen++;
    end
    check(name, seen, 0);
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd: got dir %0d, expected no command", cmd_dir);
        end else begin
          e = exp_q.pop_front();
          check("cmd_dir_handshake", int'(cmd_dir), e);
        end
      end
    end
  endtask

  initial begin
    int found;
    int pulses;
    rst_n = 1'b0; mode = 1'b0; btn = 4'b0; start = 1'b0;
    auto_valid = 1'b0; auto_dir = 2'd0; cmd_ready = 1'b0;
    fork
      monitor();
    join_none
    step(3);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_auto_ready", int'(auto_ready), 0);
    rst_n = 1'b1;
    step(1);

    // single right press held long: one command only
    cmd_ready = 1'b1;
    exp_q.push_back(3);
    btn[3] = 1'b1;
    step(12);
    btn[3] = 1'b0;
    step(1);
    wait_moves("right_move_count", 1, 8);
    watch_quiet("right_no_repeat", 8);

    // reset in the middle of a stalled ISSUE
    cmd_ready = 1'b0;
    press(1);
    wait_valid("pre_reset_valid", 10);
    check("pre_reset_dir", int'(cmd_dir), 1);
    press(0);
    press_start();
    check("pre_reset_fifo", int'(fifo_count), 1);
    check("pre_reset_paused", int'(paused), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_cmd_valid", int'(cmd_valid), 0);
    check("midrst_cmd_dir", int'(cmd_dir), 0);
    check("midrst_paused", int'(paused), 0);
    check("midrst_fifo", int'(fifo_count), 0);
    check("midrst_move_count", int'(move_count), 0);
    check("midrst_overflow", int'(overflow), 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    check("postrst_idle", int'(cmd_valid), 0);

    // six presses with world stalled: fill FIFO, drop the last
    press(2);
    exp_q.push_back(2);
    wait_valid("fill_first_issue", 10);
    check("fill_fifo_after_pop", int'(fifo_count), 0);
    press(0); exp_q.push_back(0);
    press(1); exp_q.push_back(1);
    check("stall_dir_stable", int'(cmd_dir), 2);
    press(3); exp_q.push_back(3);
    press(0); exp_q.push_back(0);
    check("full_fifo_count", int'(fifo_count), 4);
    check("full_no_overflow_yet", int'(overflow), 0);
    press(1);
    check("drop_fifo_count", int'(fifo_count), 4);
    check("drop_overflow", int'(overflow), 1);
    check("drop_dir_stable", int'(cmd_dir), 2);
    cmd_ready = 1'b1;
    wait_moves("drain_move_count", 5, 40);
    check("drain_fifo_empty", int'(fifo_count), 0);
    check("overflow_sticky", int'(overflow), 1);

    // pause while an ISSUE is stalled
    cmd_ready = 1'b0;
    press(0);
    exp_q.push_back(0);
    wait_valid("pause_issue", 10);
    press_start();
    check("pause_set", int'(paused), 1);
    press(1);
    exp_q.push_back(1);
    check("pause_fifo_push", int'(fifo_count), 1);
    cmd_ready = 1'b1;
    wait_moves("pause_inflight_done", 6, 5);
    watch_quiet("pause_blocks_loads", 16);
    check("pause_fifo_held", int'(fifo_count), 1);
    press_start();
    check("pause_cleared", int'(paused), 0);
    wait_moves("resume_move_count", 7, 12);

    // autonomous source: one request per tick
    mode = 1'b1; auto_valid = 1'b1; auto_dir = 2'd2;
    for (int k = 0; k < 4; k++) exp_q.push_back(2);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (auto_ready) found = 1;
    end
    check("auto_first_ready", found, 1);
    pulses = 0;
    repeat (3 * TICK_DIV) begin
      @(negedge clk);
      if (auto_ready) pulses++;
    end
    @(posedge clk);
    #1;
    auto_valid = 1'b0;
    check("auto_pulses_3_ticks", pulses, 3);
    step(4);
    check("auto_move_count", int'(move_count), 11);

    // mode change flushes a partially filled FIFO
    mode = 1'b0;
    step(1);
    press_start();
    check("flush_paused", int'(paused), 1);
    press(0);
    press(1);
    check("flush_fifo_before", int'(fifo_count), 2);
    mode = 1'b1;
    step(1);
    check("flush_fifo_after", int'(fifo_count), 0);
    press_start();
    cmd_ready = 1'b1;
    watch_quiet("flush_no_manual_cmd", 16);
    mode = 1'b0;
    watch_quiet("flush_back_manual_quiet", 12);
    check("flush_move_count", int'(move_count), 11);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
